// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S-entry type, PRGA state encoding and default message length.
// Used by the KSA, PRGA and decryption stages.
package rc4_pkg;

    localparam int RC4_DATA_WIDTH = 8;
    localparam int RC4_MSG_DEP    = 32;

    typedef logic [RC4_DATA_WIDTH-1:0] s_byte_t;

    localparam logic [3:0] ST_IDLE   = 4'd0;
    localparam logic [3:0] ST_INC_I  = 4'd1;
    localparam logic [3:0] ST_RD_I   = 4'd2;
    localparam logic [3:0] ST_WAIT_I = 4'd3;
    localparam logic [3:0] ST_LAT_I  = 4'd4;
    localparam logic [3:0] ST_RD_J   = 4'd5;
    localparam logic [3:0] ST_WAIT_J = 4'd6;
    localparam logic [3:0] ST_LAT_J  = 4'd7;
    localparam logic [3:0] ST_WR_I   = 4'd8;
    localparam logic [3:0] ST_WR_J   = 4'd9;
    localparam logic [3:0] ST_AVAIL  = 4'd10;
    localparam logic [3:0] ST_DONE   = 4'd11;

    typedef enum logic [3:0] {
        PRGA_IDLE   = ST_IDLE,
        PRGA_INC_I  = ST_INC_I,
        PRGA_RD_I   = ST_RD_I,
        PRGA_WAIT_I = ST_WAIT_I,
        PRGA_LAT_I  = ST_LAT_I,
        PRGA_RD_J   = ST_RD_J,
        PRGA_WAIT_J = ST_WAIT_J,
        PRGA_LAT_J  = ST_LAT_J,
        PRGA_WR_I   = ST_WR_I,
        PRGA_WR_J   = ST_WR_J,
        PRGA_AVAIL  = ST_AVAIL,
        PRGA_DONE   = ST_DONE
    } prga_state_t;

endpackage

// File: rtl/prga_swap_fsm.sv
// RC4 PRGA front end: advances i/j, swaps S[i]/S[j] in S-RAM and hands the pair downstream.
// Optional macro PRGA_STALL_CNT_EN adds the stall_cycles output (AVAIL cycles without consume).
module prga_swap_fsm
    import rc4_pkg::*;
#(
    parameter int MSG_DEP    = RC4_MSG_DEP,
    parameter int DATA_WIDTH = RC4_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic [DATA_WIDTH-1:0]         s_addr,
    output logic [DATA_WIDTH-1:0]         s_wrdata,
    output logic                          s_wren,
    input  logic [DATA_WIDTH-1:0]         s_rddata,
    output logic                          mem_grant,
    output logic [DATA_WIDTH-1:0]         s_i,
    output logic [DATA_WIDTH-1:0]         s_j,
    output logic                          s_j_available,
    input  logic                          consume,
    output logic [$clog2(MSG_DEP):0]      byte_idx,
    output logic                          done
`ifdef PRGA_STALL_CNT_EN
    ,
    output logic [15:0]                   stall_cycles
`endif
);

    localparam int              KW     = $clog2(MSG_DEP) + 1;
    localparam logic [KW-1:0]   K_LAST = KW'(MSG_DEP);

    logic [3:0]            r_state;
    logic [3:0]            w_state_nxt;
    logic [DATA_WIDTH-1:0] r_i;
    logic [DATA_WIDTH-1:0] r_j;
    logic [DATA_WIDTH-1:0] r_si;
    logic [DATA_WIDTH-1:0] r_sj;
    logic [KW-1:0]         r_k;
    logic [KW-1:0]         w_k_inc;
    logic                  w_start_ok;

    logic [DATA_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wrdata;
    logic                  w_wren;
    logic                  w_grant;
    logic [DATA_WIDTH-1:0] w_s_i;
    logic [DATA_WIDTH-1:0] w_s_j;
    logic                  w_avail;
    logic                  w_done;

    assign w_k_inc    = r_k + KW'(1);
    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    // Next-state logic for the swap sequence
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_nxt = ST_INC_I; else w_state_nxt = ST_IDLE;
            ST_INC_I:  w_state_nxt = ST_RD_I;
            ST_RD_I:   w_state_nxt = ST_WAIT_I;
            ST_WAIT_I: w_state_nxt = ST_LAT_I;
            ST_LAT_I:  w_state_nxt = ST_RD_J;
            ST_RD_J:   w_state_nxt = ST_WAIT_J;
            ST_WAIT_J: w_state_nxt = ST_LAT_J;
            ST_LAT_J:  w_state_nxt = ST_WR_I;
            ST_WR_I:   w_state_nxt = ST_WR_J;
            ST_WR_J:   w_state_nxt = ST_AVAIL;
            ST_AVAIL: begin
                if (consume) begin
                    if (w_k_inc == K_LAST) w_state_nxt = ST_DONE;
                    else                   w_state_nxt = ST_INC_I;
                end else begin
                    w_state_nxt = ST_AVAIL;
                end
            end
            ST_DONE:   if (start) w_state_nxt = ST_INC_I; else w_state_nxt = ST_DONE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register and i/j/k/S datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_si    <= '0;
            r_sj    <= '0;
            r_k     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_i <= '0;
                        r_j <= '0;
                        r_k <= '0;
                    end
                end
                ST_INC_I: r_i <= r_i + DATA_WIDTH'(1);
                ST_LAT_I: begin
                    r_si <= s_rddata;
                    r_j  <= r_j + s_rddata;
                end
                ST_LAT_J: r_sj <= s_rddata;
                ST_AVAIL: if (consume) r_k <= w_k_inc;
                default: ;
            endcase
        end
    end

    // Moore output decode; the read address is held through the wait and latch
    // cycles so a registered-output RAM still presents the right word when captured.
    always_comb begin
        w_addr   = '0;
        w_wrdata = '0;
        w_wren   = 1'b0;
        w_grant  = 1'b0;
        w_s_i    = '0;
        w_s_j    = '0;
        w_avail  = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            ST_RD_I, ST_WAIT_I, ST_LAT_I: w_addr = r_i;
            ST_RD_J, ST_WAIT_J, ST_LAT_J: w_addr = r_j;
            ST_WR_I: begin
                w_addr   = r_i;
                w_wrdata = r_sj;
                w_wren   = 1'b1;
            end
            ST_WR_J: begin
                w_addr   = r_j;
                w_wrdata = r_si;
                w_wren   = 1'b1;
            end
            ST_AVAIL: begin
                w_s_i   = r_sj;
                w_s_j   = r_si;
                w_avail = 1'b1;
                w_grant = 1'b1;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    assign s_addr        = w_addr;
    assign s_wrdata      = w_wrdata;
    assign s_wren        = w_wren;
    assign mem_grant     = w_grant;
    assign s_i           = w_s_i;
    assign s_j           = w_s_j;
    assign s_j_available = w_avail;
    assign done          = w_done;
    assign byte_idx      = r_k;

`ifdef PRGA_STALL_CNT_EN
    logic [15:0] r_stall;

    // Saturating count of AVAIL cycles the downstream stage left unconsumed
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall <= 16'h0000;
        end else if (w_start_ok) begin
            r_stall <= 16'h0000;
        end else if ((r_state == ST_AVAIL) && !consume && (r_stall != 16'hFFFF)) begin
            r_stall <= r_stall + 16'h0001;
        end else begin
            r_stall <= r_stall;
        end
    end

    assign stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_prga_swap_fsm.sv
// Directed bench for prga_swap_fsm with a behavioural S-RAM and a golden PRGA scoreboard.
// Build with +define+PRGA_STALL_CNT_EN to also check stall_cycles.
module tb_prga_swap_fsm;

    localparam int MD = 260;
    localparam int KW = $clog2(MD) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          consume;
    logic [7:0]    s_addr;
    logic [7:0]    s_wrdata;
    logic [7:0]    s_rddata;
    logic [7:0]    s_i;
    logic [7:0]    s_j;
    logic          s_wren;
    logic          mem_grant;
    logic          s_j_available;
    logic          done;
    logic [KW-1:0] byte_idx;
`ifdef PRGA_STALL_CNT_EN
    logic [15:0]   stall_cycles;
`endif

    int n_err = 0;
    int n_chk = 0;

    logic [7:0]  mem [256];
    logic [7:0]  gs  [256];
    logic [7:0]  gi;
    logic [7:0]  gj;
    logic        load_en;
    logic [31:0] exp_q [$];
    logic [15:0] wr_q  [$];

    always #5 clk = ~clk;

    prga_swap_fsm #(.MSG_DEP(MD), .DATA_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .s_addr        (s_addr),
        .s_wrdata      (s_wrdata),
        .s_wren        (s_wren),
        .s_rddata      (s_rddata),
        .mem_grant     (mem_grant),
        .s_i           (s_i),
        .s_j           (s_j),
        .s_j_available (s_j_available),
        .consume       (consume),
        .byte_idx      (byte_idx),
        .done          (done)
`ifdef PRGA_STALL_CNT_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    // Synchronous-read S-RAM, loadable from the model array
    always @(posedge clk) begin
        if (load_en) begin
            for (int a = 0; a < 256; a++) mem[a] <= gs[a];
        end else if (s_wren) begin
            mem[s_addr] <= s_wrdata;
        end
        s_rddata <= mem[s_addr];
    end

    // Log every DUT write for per-byte comparison
    always @(posedge clk) begin
        if (s_wren && !load_en) wr_q.push_back({s_addr, s_wrdata});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_step();
        logic [7:0] t;
        gi = gi + 8'd1;
        gj = gj + gs[gi];
        t      = gs[gi];
        gs[gi] = gs[gj];
        gs[gj] = t;
        exp_q.push_back({gi, gj, gs[gi], gs[gj]});
    endtask

    task automatic start_run();
        @(negedge clk);
        start = 1'b1;
        gi = 8'd0;
        gj = 8'd0;
        model_step();
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_avail(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_j_available) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("avail_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_byte(input int k, input bit hold, input bit last);
        bit          ok;
        logic [31:0] e;
        logic [15:0] w;
        wait_avail(ok);
        if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
            e = 32'd0;
        end else begin
            e = exp_q.pop_front();
        end
        chk("s_i", 32'(s_i), 32'(e[15:8]));
        chk("s_j", 32'(s_j), 32'(e[7:0]));
        chk("byte_idx", 32'(byte_idx), 32'(k));
        chk("grant_avail", 32'(mem_grant), 32'd1);
        chk("wren_avail", 32'(s_wren), 32'd0);
        if (wr_q.size() == 2) begin
            w = wr_q.pop_front();
            chk("wr_i", 32'(w), 32'({e[31:24], e[15:8]}));
            if (k == 255) chk("wrap_i_addr", 32'(w[15:8]), 32'd0);
            w = wr_q.pop_front();
            chk("wr_j", 32'(w), 32'({e[23:16], e[7:0]}));
        end else begin
            chk("wr_count", 32'(wr_q.size()), 32'd2);
            wr_q.delete();
        end
        if (hold) begin
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                @(negedge clk);
                chk("hold_avail", 32'(s_j_available), 32'd1);
                chk("hold_s_i", 32'(s_i), 32'(e[15:8]));
                chk("hold_s_j", 32'(s_j), 32'(e[7:0]));
                chk("hold_grant", 32'(mem_grant), 32'd1);
                chk("hold_wren", 32'(s_wren), 32'd0);
            end
            chk("hold_no_writes", 32'(wr_q.size()), 32'd0);
`ifdef PRGA_STALL_CNT_EN
            chk("stall_cycles", 32'(stall_cycles), 32'd20);
`endif
        end
        consume = 1'b1;
        @(posedge clk);
        #1 consume = 1'b0;
        if (!last) model_step();
    endtask

    task automatic check_end(input string tag);
        int bad;
        @(negedge clk);
        chk("done_after_last", 32'(done), 32'd1);
        chk("byte_idx_end", 32'(byte_idx), 32'(MD));
        chk("grant_done", 32'(mem_grant), 32'd0);
        chk("avail_done", 32'(s_j_available), 32'd0);
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== gs[a]) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    initial begin
        bit ok;
        int r;
        logic [7:0] t;
        reset   = 1'b1;
        start   = 1'b0;
        consume = 1'b0;
        load_en = 1'b1;
        for (int a = 0; a < 256; a++) gs[a] = 8'(a);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr", 32'(s_addr), 32'd0);
        chk("rst_wren", 32'(s_wren), 32'd0);
        chk("rst_grant", 32'(mem_grant), 32'd0);
        chk("rst_avail", 32'(s_j_available), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_byte_idx", 32'(byte_idx), 32'd0);
        chk("rst_s_ij", 32'({s_i, s_j}), 32'd0);
`ifdef PRGA_STALL_CNT_EN
        chk("rst_stall", 32'(stall_cycles), 32'd0);
`endif
        reset   = 1'b0;
        load_en = 1'b0;

        // Identity S: bytes 0/1 known values, stall hold on byte 2, stray pulses after it
        start_run();
        for (int k = 0; k < MD; k++) begin
            if (k == 0) begin
                wait_avail(ok);
                chk("id_k0_s_i", 32'(s_i), 32'd1);
                chk("id_k0_s_j", 32'(s_j), 32'd1);
            end
            do_byte(k, k == 2, k == MD - 1);
            if (k == 1) begin
                chk("id_mem2", 32'(mem[2]), 32'd3);
                chk("id_mem3", 32'(mem[3]), 32'd2);
            end
            if (k == 2) begin
                @(negedge clk);
                start   = 1'b1;
                consume = 1'b1;
                @(negedge clk);
                start   = 1'b0;
                consume = 1'b0;
                chk("stray_byte_idx", 32'(byte_idx), 32'd3);
            end
        end
        check_end("final_S_identity");

        // Restart from DONE on the scrambled S, then reset in WR_I
        start_run();
        @(negedge clk);
        chk("restart_done_clr", 32'(done), 32'd0);
        chk("restart_k_clr", 32'(byte_idx), 32'd0);
        do_byte(0, 1'b0, 1'b0);
        do_byte(1, 1'b0, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (s_wren) begin
                ok = 1'b1;
                break;
            end
        end
        chk("reach_wr_i", 32'(ok), 32'd1);
        chk("wr_i_addr", 32'(s_addr), 32'(exp_q[0][31:24]));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_wren", 32'(s_wren), 32'd0);
        chk("mid_rst_avail", 32'(s_j_available), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_grant", 32'(mem_grant), 32'd0);
        chk("mid_rst_addr", 32'(s_addr), 32'd0);
        chk("mid_rst_byte_idx", 32'(byte_idx), 32'd0);

        // Random permutation S against the golden model
        for (int a = 0; a < 256; a++) gs[a] = 8'(a);
        for (int a = 255; a > 0; a--) begin
            r = int'($urandom_range(a, 0));
            t = gs[a];
            gs[a] = gs[r];
            gs[r] = t;
        end
        load_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_en = 1'b0;
        reset   = 1'b0;
        exp_q.delete();
        wr_q.delete();
        start_run();
        for (int k = 0; k < MD; k++) do_byte(k, 1'b0, k == MD - 1);
        check_end("final_S_random");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
